// File: rtl/ball_launcher.sv
// ============================================================================
//  Module      : ball_launcher
//  Description : Hopper release sequencer for the marble board; lever edges
//                release the next ball, and interception, an empty hopper or
//                a lost ball halts the run.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ball_launcher #(
    parameter int BLUE_BALLS = 8,
    parameter int RED_BALLS  = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_lever_left,
    input  logic       i_lever_right,
    input  logic       i_intercepted,
    output logic       o_release_blue,
    output logic       o_release_red,
    output logic [3:0] o_blue_left,
    output logic [3:0] o_red_left,
    output logic [4:0] o_released,
    output logic       o_busy,
    output logic       o_done,
    output logic [1:0] o_halt_reason,
    output logic       o_collision
);

    localparam logic [3:0] c_BLUE         = 4'(BLUE_BALLS);
    localparam logic [3:0] c_RED          = 4'(RED_BALLS);
    localparam logic [7:0] c_TIMEOUT      = 8'(TIMEOUT);
    localparam logic [4:0] c_MAX_RELEASED = 5'd30;

    localparam logic [1:0] c_REASON_NONE      = 2'd0;
    localparam logic [1:0] c_REASON_INTERCEPT = 2'd1;
    localparam logic [1:0] c_REASON_EMPTY     = 2'd2;
    localparam logic [1:0] c_REASON_TIMEOUT   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FLIGHT = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t     r_state, w_state;
    logic [3:0] r_blue, w_blue;
    logic [3:0] r_red, w_red;
    logic [4:0] r_released, w_released;
    logic [7:0] r_timer, w_timer;
    logic [1:0] r_reason, w_reason;
    logic       r_collision, w_collision;
    logic       r_rel_blue, w_rel_blue;
    logic       r_rel_red, w_rel_red;
    logic       r_left_q, r_right_q;

    logic       w_left_rise, w_right_rise;
    logic [4:0] w_released_inc;

    assign w_left_rise    = i_lever_left & ~r_left_q;
    assign w_right_rise   = i_lever_right & ~r_right_q;
    assign w_released_inc = (r_released < c_MAX_RELEASED) ? r_released + 5'd1 : r_released;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_blue      <= c_BLUE;
            r_red       <= c_RED;
            r_released  <= 5'd0;
            r_timer     <= 8'd0;
            r_reason    <= c_REASON_NONE;
            r_collision <= 1'b0;
            r_rel_blue  <= 1'b0;
            r_rel_red   <= 1'b0;
            r_left_q    <= 1'b0;
            r_right_q   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_blue      <= w_blue;
            r_red       <= w_red;
            r_released  <= w_released;
            r_timer     <= w_timer;
            r_reason    <= w_reason;
            r_collision <= w_collision;
            r_rel_blue  <= w_rel_blue;
            r_rel_red   <= w_rel_red;
            r_left_q    <= i_lever_left;
            r_right_q   <= i_lever_right;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_blue      = r_blue;
        w_red       = r_red;
        w_released  = r_released;
        w_timer     = r_timer;
        w_reason    = r_reason;
        w_collision = r_collision;
        w_rel_blue  = 1'b0;
        w_rel_red   = 1'b0;

        case (r_state)
            S_IDLE, S_HALTED: begin
                if (i_start) begin
                    w_blue      = c_BLUE - 4'd1;
                    w_red       = c_RED;
                    w_released  = 5'd1;
                    w_timer     = 8'd0;
                    w_reason    = c_REASON_NONE;
                    w_collision = 1'b0;
                    w_rel_blue  = 1'b1;
                    w_state     = S_FLIGHT;
                end
            end
            S_FLIGHT: begin
                // Saturating count keeps the timer from ever passing TIMEOUT.
                if (r_timer < c_TIMEOUT)
                    w_timer = r_timer + 8'd1;

                if (i_intercepted) begin
                    w_state  = S_HALTED;
                    w_reason = c_REASON_INTERCEPT;
                end else if (w_left_rise) begin
                    if (w_right_rise)
                        w_collision = 1'b1;
                    if (r_blue != 4'd0) begin
                        w_blue     = r_blue - 4'd1;
                        w_released = w_released_inc;
                        w_timer    = 8'd0;
                        w_rel_blue = 1'b1;
                    end else begin
                        w_state  = S_HALTED;
                        w_reason = c_REASON_EMPTY;
                    end
                end else if (w_right_rise) begin
                    if (r_red != 4'd0) begin
                        w_red      = r_red - 4'd1;
                        w_released = w_released_inc;
                        w_timer    = 8'd0;
                        w_rel_red  = 1'b1;
                    end else begin
                        w_state  = S_HALTED;
                        w_reason = c_REASON_EMPTY;
                    end
                end else if (r_timer == c_TIMEOUT) begin
                    w_state  = S_HALTED;
                    w_reason = c_REASON_TIMEOUT;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign o_release_blue = r_rel_blue;
    assign o_release_red  = r_rel_red;
    assign o_blue_left    = r_blue;
    assign o_red_left     = r_red;
    assign o_released     = r_released;
    assign o_busy         = (r_state == S_FLIGHT);
    assign o_done         = (r_state == S_HALTED);
    assign o_halt_reason  = r_reason;
    assign o_collision    = r_collision;

endmodule

`default_nettype wire

// File: doc/ball_launcher.md
Name: ball_launcher

Overview:
- Clocked sequencer for the marble board's two hoppers: blue (left) and red (right).
- Releases the first blue ball on start. After that, each ball reaching the bottom left lever releases the next blue ball, and each ball reaching the right lever releases the next red ball.
- Halts the run on any of: interceptor capture, an empty hopper being requested, or a ball lost in flight (timeout).
- Sits between the board fabric (ramps, bits, interceptors) and the hopper release actuators.

Parameters:
- BLUE_BALLS, 8: initial blue hopper count, 1..15.
- RED_BALLS, 8: initial red hopper count, 1..15.
- TIMEOUT, 255: maximum cycles a ball may be in flight before halting, 1..255.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_start  input  1  start or restart pulse.
- i_lever_left  input  1  level; high while a ball is on the left lever.
- i_lever_right  input  1  level; high while a ball is on the right lever.
- i_intercepted  input  1  level; OR of all interceptor occupied flags.
- o_release_blue  output  1  one-cycle pulse to the blue actuator.
- o_release_red  output  1  one-cycle pulse to the red actuator.
- o_blue_left  output  4  blue balls remaining.
- o_red_left  output  4  red balls remaining.
- o_released  output  5  total balls released this run.
- o_busy  output  1  high in FLIGHT.
- o_done  output  1  high in HALTED.
- o_halt_reason  output  2  0 none, 1 intercepted, 2 hopper empty, 3 timeout.
- o_collision  output  1  sticky; both levers rose in the same cycle.

Behaviour:
- Reset: all registered state updates on the rising i_clk edge while i_rst is high.
  - State goes to IDLE.
  - Counts reload: o_blue_left=BLUE_BALLS, o_red_left=RED_BALLS.
  - o_released, the timer, o_halt_reason and o_collision go to 0.
  - Both lever edge-history registers go to 0.
  - o_release_blue, o_release_red, o_busy and o_done are 0.
  - Reset mid-flight aborts the run immediately; no release pulse follows.
- Lever edges: an edge counts only when the input is 1 at edge N and the stored previous sample is 0. A lever held high does not retrigger. The history registers update every cycle in every state.
- IDLE:
  - i_start=1 reloads both counts to the parameters and clears o_released, o_halt_reason and o_collision.
  - If BLUE_BALLS>0: o_release_blue is high for exactly one cycle, after the edge that samples i_start. Blue decrements, o_released increments, the timer clears, and the state goes to FLIGHT.
- FLIGHT: the timer increments every cycle. Events are evaluated at each edge in this priority order:
  1. i_intercepted=1 → HALTED, reason 1. No release that cycle.
  2. Left edge:
     - blue>0: pulse o_release_blue the next cycle, decrement blue, increment o_released, clear the timer.
     - blue==0: HALTED, reason 2.
  3. Right edge: same as left, using red and o_release_red.
  4. Timer == TIMEOUT with no event → HALTED, reason 3.
- Simultaneous lever edges: left is serviced, right is ignored, and o_collision sets.
- A lever edge and timeout in the same cycle: the lever wins and the timer clears.
- HALTED:
  - o_done=1; counts and reason hold.
  - Lever edges and i_intercepted are ignored.
  - i_start behaves as in IDLE: reload and release the first blue ball.
  - i_start in FLIGHT is ignored.
- Release pulses:
  - At most one of o_release_blue and o_release_red is high in any cycle.
  - Neither pulse ever lasts more than one cycle.
  - Latency is exactly one cycle from the sampling edge.
- Counters:
  - Hopper counts never wrap below 0.
  - o_released saturates at 30, which equals BLUE_BALLS+RED_BALLS at their maximum of 15 each.
  - The timer is 8 bits and never exceeds TIMEOUT.

Test Plan:
1. Reset then start → o_release_blue is high for 1 cycle, o_blue_left=7, o_released=1, o_busy=1. Then a left lever edge at t+20 → o_release_blue pulses at t+21, blue=6, released=2.
2. Start, then 8 right lever edges → 8 o_release_red pulses, red reaches 0. A 9th right edge → o_done=1, o_halt_reason=2, and no pulse.
3. Start with TIMEOUT=10 and no lever edges → o_done=1 and o_halt_reason=3 exactly 10 cycles after the release pulse. A lever edge on cycle 10 instead keeps FLIGHT and restarts the timer.
4. In FLIGHT, assert i_intercepted and a left edge in the same cycle → HALTED, reason 1, no release pulse. Then i_start → counts reload to 8/8, reason clears, and blue pulses.
5. Both levers rise in the same cycle → a single blue pulse, o_collision=1, red unchanged. Holding i_lever_left high for 50 cycles causes no further pulses.
6. Assert i_rst mid-flight, in the cycle after a lever edge → no release pulse. Outputs return to their reset values: o_blue_left=8, o_red_left=8, o_busy=0.
